// File: rtl/branch_resolve_queue_pkg.sv
// Shared types and constants for the branch resolve queue and its predictor-side consumers.
package branch_resolve_queue_pkg;

  localparam int unsigned IDX_W    = 7;
  localparam int unsigned DEF_PC_W = 32;

  // 2-bit PHT saturating-counter encoding driven by the update strobe.
  typedef enum logic [1:0] {
    PHT_SNT = 2'b00,
    PHT_WNT = 2'b01,
    PHT_WT  = 2'b10,
    PHT_ST  = 2'b11
  } pht_state_e;

  typedef struct packed {
    logic [DEF_PC_W-1:0] pc;
    logic                taken;
    logic [IDX_W-1:0]    idx;
    logic [DEF_PC_W-1:0] target;
  } brq_entry_t;

endpackage

// File: rtl/branch_resolve_queue_if.sv
// Fetch push, execute resolve and predictor-update/redirect signals of the branch resolve queue.
interface branch_resolve_queue_if #(
  parameter int unsigned PC_W  = branch_resolve_queue_pkg::DEF_PC_W,
  parameter int unsigned IDX_W = branch_resolve_queue_pkg::IDX_W,
  parameter int unsigned CNT_W = 4
);
  logic             push_valid;
  logic             push_ready;
  logic [PC_W-1:0]  push_pc;
  logic             push_taken;
  logic [IDX_W-1:0] push_idx;
  logic [PC_W-1:0]  push_target;
  logic             res_valid;
  logic             res_ready;
  logic             res_taken;
  logic [PC_W-1:0]  res_target;
  logic             upd_valid;
  logic [IDX_W-1:0] upd_idx;
  logic             upd_taken;
  logic             mispredict;
  logic [PC_W-1:0]  redirect_pc;
  logic [CNT_W-1:0] count;

  modport master (
    output push_valid, push_pc, push_taken, push_idx, push_target,
    output res_valid, res_taken, res_target,
    input  push_ready, res_ready, upd_valid, upd_idx, upd_taken,
    input  mispredict, redirect_pc, count
  );

  modport slave (
    input  push_valid, push_pc, push_taken, push_idx, push_target,
    input  res_valid, res_taken, res_target,
    output push_ready, res_ready, upd_valid, upd_idx, upd_taken,
    output mispredict, redirect_pc, count
  );
endinterface

// File: rtl/branch_resolve_queue_storage.sv
// Entry register file for the branch resolve queue: one write port, one async read port at the head.
module brq_storage #(
  parameter  int unsigned DEPTH   = 8,
  parameter  type         entry_t = logic,
  localparam int unsigned PTR_W   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             wr_en,
  input  logic [PTR_W-1:0] wr_ptr,
  input  entry_t           wr_data,
  input  logic [PTR_W-1:0] rd_ptr,
  output entry_t           rd_data
);
  // Contents are don't-care until written, so no reset on the array.
  entry_t mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= wr_data;
  end

  assign rd_data = mem[rd_ptr];
endmodule

// File: rtl/branch_resolve_queue.sv
// In-order queue of predicted branches: resolves the head, strobes the PHT update and redirects fetch on mispredict.
module branch_resolve_queue #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned PC_W  = branch_resolve_queue_pkg::DEF_PC_W,
  parameter int unsigned IDX_W = branch_resolve_queue_pkg::IDX_W
) (
  input logic                   clk,
  input logic                   resetn,
  branch_resolve_queue_if.slave brq
);
  import branch_resolve_queue_pkg::*;

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  typedef struct packed {
    logic [PC_W-1:0]  pc;
    logic             taken;
    logic [IDX_W-1:0] idx;
    logic [PC_W-1:0]  target;
  } entry_t;

  logic [PTR_W-1:0] rd_ptr, wr_ptr, rd_ptr_nxt, wr_ptr_nxt;
  logic [CNT_W-1:0] count_q, count_nxt;
  entry_t           head, wr_entry;
  logic             full, empty, push_fire, res_fire, mispred_c, flush;

  logic             upd_valid_q, upd_taken_q, mispredict_q;
  logic [IDX_W-1:0] upd_idx_q;
  logic [PC_W-1:0]  redirect_pc_q;

  assign full      = (count_q == CNT_W'(DEPTH));
  assign empty     = (count_q == '0);
  assign push_fire = brq.push_valid & ~full;
  assign res_fire  = brq.res_valid & ~empty;

  assign mispred_c = (head.taken != brq.res_taken) |
                     (head.taken & brq.res_taken & (head.target != brq.res_target));
  assign flush     = res_fire & mispred_c;

  assign wr_entry = '{pc: brq.push_pc, taken: brq.push_taken, idx: brq.push_idx, target: brq.push_target};

  // A push landing on the flush edge is wrong-path and never written.
  brq_storage #(.DEPTH(DEPTH), .entry_t(entry_t)) u_storage (
    .clk     (clk),
    .wr_en   (push_fire & ~flush),
    .wr_ptr  (wr_ptr),
    .wr_data (wr_entry),
    .rd_ptr  (rd_ptr),
    .rd_data (head)
  );

  // Next pointer/occupancy; a mispredict empties the whole queue.
  always_comb begin
    rd_ptr_nxt = rd_ptr;
    wr_ptr_nxt = wr_ptr;
    count_nxt  = count_q;
    if (flush) begin
      rd_ptr_nxt = '0;
      wr_ptr_nxt = '0;
      count_nxt  = '0;
    end else begin
      if (push_fire) wr_ptr_nxt = wr_ptr + PTR_W'(1);
      if (res_fire)  rd_ptr_nxt = rd_ptr + PTR_W'(1);
      count_nxt = count_q + CNT_W'(push_fire) - CNT_W'(res_fire);
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rd_ptr        <= '0;
      wr_ptr        <= '0;
      count_q       <= '0;
      upd_valid_q   <= 1'b0;
      upd_idx_q     <= '0;
      upd_taken_q   <= 1'b0;
      mispredict_q  <= 1'b0;
      redirect_pc_q <= '0;
    end else begin
      rd_ptr       <= rd_ptr_nxt;
      wr_ptr       <= wr_ptr_nxt;
      count_q      <= count_nxt;
      upd_valid_q  <= res_fire;
      mispredict_q <= flush;
      if (res_fire) begin
        upd_idx_q   <= head.idx;
        upd_taken_q <= brq.res_taken;
      end
      if (flush) begin
        redirect_pc_q <= brq.res_taken ? brq.res_target : head.pc + PC_W'(4);
      end
    end
  end

  assign brq.push_ready  = ~full;
  assign brq.res_ready   = ~empty;
  assign brq.upd_valid   = upd_valid_q;
  assign brq.upd_idx     = upd_idx_q;
  assign brq.upd_taken   = upd_taken_q;
  assign brq.mispredict  = mispredict_q;
  assign brq.redirect_pc = redirect_pc_q;
  assign brq.count       = count_q;
endmodule

// File: tb/tb_branch_resolve_queue.sv
// Directed bench for branch_resolve_queue: vector table plus interleave and mid-operation reset sequences.
module tb_branch_resolve_queue;
  import branch_resolve_queue_pkg::*;

  localparam int unsigned DEPTH = 8;
  localparam int unsigned PC_W  = DEF_PC_W;
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  logic clk    = 1'b0;
  logic resetn = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  branch_resolve_queue_if #(.PC_W(PC_W), .IDX_W(IDX_W), .CNT_W(CNT_W)) bus ();

  branch_resolve_queue #(.DEPTH(DEPTH), .PC_W(PC_W), .IDX_W(IDX_W)) dut (
    .clk    (clk),
    .resetn (resetn),
    .brq    (bus)
  );

  typedef struct {
    logic             pv;
    logic [PC_W-1:0]  pc;
    logic             pt;
    logic [IDX_W-1:0] pidx;
    logic [PC_W-1:0]  ptgt;
    logic             rv;
    logic             rt;
    logic [PC_W-1:0]  rtgt;
    logic [CNT_W-1:0] ec;
    logic             eu;
    logic [IDX_W-1:0] eidx;
    logic             eut;
    logic             em;
    logic [PC_W-1:0]  ered;
  } vec_t;

  vec_t       vecs[$];
  brq_entry_t mq[$];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic void add(input logic pv, input logic [31:0] pc, input logic pt, input int pidx,
                              input logic [31:0] ptgt, input logic rv, input logic rt, input logic [31:0] rtgt,
                              input int ec, input logic eu, input int eidx, input logic eut,
                              input logic em, input logic [31:0] ered);
    vec_t v;
    v.pv = pv; v.pc = pc; v.pt = pt; v.pidx = IDX_W'(pidx); v.ptgt = ptgt;
    v.rv = rv; v.rt = rt; v.rtgt = rtgt;
    v.ec = CNT_W'(ec); v.eu = eu; v.eidx = IDX_W'(eidx); v.eut = eut; v.em = em; v.ered = ered;
    vecs.push_back(v);
  endfunction

  task automatic idle();
    bus.push_valid = 1'b0; bus.push_pc = '0; bus.push_taken = 1'b0; bus.push_idx = '0; bus.push_target = '0;
    bus.res_valid = 1'b0; bus.res_taken = 1'b0; bus.res_target = '0;
  endtask

  task automatic drive_push(input brq_entry_t e);
    bus.push_valid = 1'b1; bus.push_pc = e.pc; bus.push_taken = e.taken;
    bus.push_idx = e.idx; bus.push_target = e.target;
  endtask

  function automatic brq_entry_t mk(input int k);
    brq_entry_t e;
    e.pc     = 32'h1000 + 32'(4 * k);
    e.taken  = k[0];
    e.idx    = IDX_W'((k * 5) % 128);
    e.target = 32'h2000 + 32'(16 * k);
    return e;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    brq_entry_t e, h;
    idle();

    // Vector table: inputs for one cycle, expected outputs right after that edge.
    for (int i = 0; i < 8; i++)
      add(1'b1, 32'h100 + 32'(4 * i), 1'b0, i, 32'h0, 1'b0, 1'b0, 32'h0, i + 1, 1'b0, 0, 1'b0, 1'b0, 32'h0);
    add(1'b1, 32'h999, 1'b1, 77, 32'h5555, 1'b0, 1'b0, 32'h0, 8, 1'b0, 0, 1'b0, 1'b0, 32'h0);
    for (int i = 0; i < 8; i++)
      add(1'b0, 32'h0, 1'b0, 0, 32'h0, 1'b1, 1'b0, 32'h0, 7 - i, 1'b1, i, 1'b0, 1'b0, 32'h0);
    add(1'b0, 32'h0, 1'b0, 0, 32'h0, 1'b1, 1'b1, 32'h44, 0, 1'b0, 0, 1'b0, 1'b0, 32'h0);
    add(1'b1, 32'h200, 1'b0, 5, 32'h0, 1'b0, 1'b0, 32'h0, 1, 1'b0, 0, 1'b0, 1'b0, 32'h0);
    add(1'b0, 32'h0, 1'b0, 0, 32'h0, 1'b1, 1'b0, 32'h0, 0, 1'b1, 5, 1'b0, 1'b0, 32'h0);
    for (int i = 0; i < 4; i++)
      add(1'b1, 32'h300 + 32'(4 * i), 1'b0, 9 + i, 32'h0, 1'b0, 1'b0, 32'h0, i + 1, 1'b0, 0, 1'b0, 1'b0, 32'h0);
    add(1'b1, 32'h999, 1'b0, 99, 32'h0, 1'b1, 1'b1, 32'h400, 0, 1'b1, 9, 1'b1, 1'b1, 32'h400);
    add(1'b0, 32'h0, 1'b0, 0, 32'h0, 1'b0, 1'b0, 32'h0, 0, 1'b0, 0, 1'b0, 1'b0, 32'h0);
    add(1'b1, 32'h500, 1'b1, 20, 32'h600, 1'b0, 1'b0, 32'h0, 1, 1'b0, 0, 1'b0, 1'b0, 32'h0);
    add(1'b0, 32'h0, 1'b0, 0, 32'h0, 1'b1, 1'b1, 32'h640, 0, 1'b1, 20, 1'b1, 1'b1, 32'h640);
    add(1'b1, 32'h700, 1'b1, 30, 32'h800, 1'b0, 1'b0, 32'h0, 1, 1'b0, 0, 1'b0, 1'b0, 32'h0);
    add(1'b0, 32'h0, 1'b0, 0, 32'h0, 1'b1, 1'b1, 32'h800, 0, 1'b1, 30, 1'b1, 1'b0, 32'h0);
    add(1'b1, 32'hFFFF_FFFC, 1'b1, 127, 32'h1234, 1'b0, 1'b0, 32'h0, 1, 1'b0, 0, 1'b0, 1'b0, 32'h0);
    add(1'b0, 32'h0, 1'b0, 0, 32'h0, 1'b1, 1'b0, 32'h0, 0, 1'b1, 127, 1'b0, 1'b1, 32'h0);
    add(1'b1, 32'hA00, 1'b0, 3, 32'h0, 1'b1, 1'b1, 32'h123, 1, 1'b0, 0, 1'b0, 1'b0, 32'h0);
    add(1'b0, 32'h0, 1'b0, 0, 32'h0, 1'b1, 1'b0, 32'h0, 0, 1'b1, 3, 1'b0, 1'b0, 32'h0);

    // Reset state
    step(); step();
    chk("reset count", 64'(bus.count), 64'(0));
    chk("reset push_ready", 64'(bus.push_ready), 64'(1));
    chk("reset res_ready", 64'(bus.res_ready), 64'(0));
    chk("reset upd_valid", 64'(bus.upd_valid), 64'(0));
    chk("reset upd_idx", 64'(bus.upd_idx), 64'(0));
    chk("reset upd_taken", 64'(bus.upd_taken), 64'(0));
    chk("reset mispredict", 64'(bus.mispredict), 64'(0));
    chk("reset redirect_pc", 64'(bus.redirect_pc), 64'(0));
    resetn = 1'b1;

    foreach (vecs[i]) begin
      bus.push_valid = vecs[i].pv; bus.push_pc = vecs[i].pc; bus.push_taken = vecs[i].pt;
      bus.push_idx = vecs[i].pidx; bus.push_target = vecs[i].ptgt;
      bus.res_valid = vecs[i].rv; bus.res_taken = vecs[i].rt; bus.res_target = vecs[i].rtgt;
      step();
      chk($sformatf("v%0d count", i), 64'(bus.count), 64'(vecs[i].ec));
      chk($sformatf("v%0d push_ready", i), 64'(bus.push_ready), 64'(vecs[i].ec < CNT_W'(DEPTH)));
      chk($sformatf("v%0d res_ready", i), 64'(bus.res_ready), 64'(vecs[i].ec != '0));
      chk($sformatf("v%0d upd_valid", i), 64'(bus.upd_valid), 64'(vecs[i].eu));
      chk($sformatf("v%0d mispredict", i), 64'(bus.mispredict), 64'(vecs[i].em));
      if (vecs[i].eu) begin
        chk($sformatf("v%0d upd_idx", i), 64'(bus.upd_idx), 64'(vecs[i].eidx));
        chk($sformatf("v%0d upd_taken", i), 64'(bus.upd_taken), 64'(vecs[i].eut));
      end
      if (vecs[i].em)
        chk($sformatf("v%0d redirect_pc", i), 64'(bus.redirect_pc), 64'(vecs[i].ered));
    end
    idle();

    // Interleave: steady occupancy of 3 with simultaneous push and correct resolve, pointers wrap.
    for (int k = 0; k < 3; k++) begin
      e = mk(k);
      drive_push(e);
      mq.push_back(e);
      step();
      chk("il fill count", 64'(bus.count), 64'(k + 1));
    end
    for (int k = 3; k < 23; k++) begin
      e = mk(k);
      drive_push(e);
      bus.res_valid  = 1'b1;
      bus.res_taken  = mq[0].taken;
      bus.res_target = mq[0].target;
      step();
      h = mq.pop_front();
      mq.push_back(e);
      chk($sformatf("il%0d count", k), 64'(bus.count), 64'(3));
      chk($sformatf("il%0d upd_valid", k), 64'(bus.upd_valid), 64'(1));
      chk($sformatf("il%0d upd_idx", k), 64'(bus.upd_idx), 64'(h.idx));
      chk($sformatf("il%0d upd_taken", k), 64'(bus.upd_taken), 64'(h.taken));
      chk($sformatf("il%0d mispredict", k), 64'(bus.mispredict), 64'(0));
    end
    bus.push_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      bus.res_valid  = 1'b1;
      bus.res_taken  = mq[0].taken;
      bus.res_target = mq[0].target;
      step();
      h = mq.pop_front();
      chk("il drain count", 64'(bus.count), 64'(2 - k));
      chk("il drain upd_idx", 64'(bus.upd_idx), 64'(h.idx));
      chk("il drain mispredict", 64'(bus.mispredict), 64'(0));
    end
    idle();

    // Mid-operation reset: kills a live update strobe and the queued entries immediately.
    for (int k = 0; k < 5; k++) begin
      e = mk(40 + 2 * k);
      drive_push(e);
      step();
    end
    bus.push_valid = 1'b0;
    bus.res_valid  = 1'b1;
    bus.res_taken  = 1'b0;
    step();
    chk("prerst upd_valid", 64'(bus.upd_valid), 64'(1));
    chk("prerst count", 64'(bus.count), 64'(4));
    #2;
    resetn = 1'b0;
    #1;
    chk("midrst upd_valid", 64'(bus.upd_valid), 64'(0));
    chk("midrst mispredict", 64'(bus.mispredict), 64'(0));
    chk("midrst count", 64'(bus.count), 64'(0));
    chk("midrst push_ready", 64'(bus.push_ready), 64'(1));
    chk("midrst res_ready", 64'(bus.res_ready), 64'(0));
    bus.push_valid = 1'b1;
    bus.res_taken  = 1'b1;
    step();
    idle();
    resetn = 1'b1;
    step();
    chk("postrst upd_valid", 64'(bus.upd_valid), 64'(0));
    chk("postrst mispredict", 64'(bus.mispredict), 64'(0));
    chk("postrst count", 64'(bus.count), 64'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
